// File: rtl/division.sv
// Signed N-bit restoring divider (quotient truncates toward zero, remainder takes dividend sign).
// Define DIV_ZERO_DETECT_EN to add the div_zero flag and a one-cycle bypass for B==0.
module division #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         done
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic         div_zero
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  bmag_q;
  logic          sign_a_q;
  logic          sign_q_q;

  logic [N-1:0]  amag_d;
  logic [N-1:0]  bmag_d;
  logic [N+1:0]  shift_d;
  logic [N+1:0]  trial_d;
  logic [N:0]    rem_d;
  logic [N-1:0]  quo_d;

  // One restoring step: the dividend register shifts out its MSB and collects quotient bits.
  always_comb begin
    amag_d  = A[N-1] ? -A : A;
    bmag_d  = B[N-1] ? -B : B;
    shift_d = {rem_q, quo_q[N-1]};
    trial_d = shift_d - {2'b00, bmag_q};
    rem_d   = shift_d[N:0];
    quo_d   = {quo_q[N-2:0], 1'b0};
    if (!trial_d[N+1]) begin
      rem_d = trial_d[N:0];
      quo_d = {quo_q[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      Q        <= '0;
      R        <= '0;
      done     <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            rem_q    <= '0;
            quo_q    <= amag_d;
            bmag_q   <= bmag_d;
            sign_a_q <= A[N-1];
            sign_q_q <= A[N-1] ^ B[N-1];
            cnt_q    <= CW'(N);
            state_q  <= ITER;
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
            // Zero divisor skips the iterations; SIGN then reproduces A as the remainder.
            if (B == '0) begin
              quo_q    <= '0;
              rem_q    <= {1'b0, amag_d};
              cnt_q    <= '0;
              div_zero <= 1'b1;
              state_q  <= SIGN;
            end
`endif
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          Q       <= sign_q_q ? -quo_q : quo_q;
          R       <= sign_a_q ? -rem_q[N-1:0] : rem_q[N-1:0];
          done    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Randomised and directed bench for the signed divider, checked against integer arithmetic.
// Follows DIV_ZERO_DETECT_EN to select the expected divide-by-zero behaviour.
module tb_division;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       done;
`ifdef DIV_ZERO_DETECT_EN
  logic       div_zero;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  division #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .A(A),
    .B(B),
    .Q(Q),
    .R(R),
    .done(done)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_zero(div_zero)
`endif
  );

  function automatic logic dz_now();
`ifdef DIV_ZERO_DETECT_EN
    return div_zero;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: integer division truncates toward zero and % follows the dividend sign.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output int lat);
    int ai;
    int bi;
    ai = $signed(a);
    bi = $signed(b);
    dz = 1'b0;
    lat = N + 1;
    if (bi == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      q = 8'h00;
      r = a;
      dz = 1'b1;
      lat = 1;
`else
      q = 8'((ai < 0) ? -255 : 255);
      r = a;
`endif
    end else begin
      q = 8'(ai / bi);
      r = 8'(ai % bi);
    end
  endfunction

  // Called just after a falling edge; returns what the DUT produced.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output int lat, output logic done_after, output logic dz);
    valid = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = Q;
    r = R;
    dz = dz_now();
    @(negedge clk);
    done_after = done;
    $display("op A=%0d B=%0d -> Q=%h R=%h dz=%0b latency=%0d", $signed(a), $signed(b), q, r, dz, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid = 1'b0;
    A = 8'h00;
    B = 8'h00;
    #3;
    checks++;
    if ({Q, R, done, dz_now()} !== 18'h0)
      $display("FAIL reset_async Q=%h R=%h done=%b dz=%b expected all zero", Q, R, done, dz_now());
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({Q, R, done} !== 17'h0)
      $display("FAIL reset_idle Q=%h R=%h done=%b expected all zero", Q, R, done);
    else passes++;
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q, r, eq, er;
    logic       da, dz, edz;
    int         lat, elat;
    model(a, b, eq, er, edz, elat);
    run_op(a, b, q, r, lat, da, dz);
    checks++;
    if (q !== eq || r !== er)
      $display("FAIL %s_result A=%h B=%h got Q=%h R=%h expected Q=%h R=%h", name, a, b, q, r, eq, er);
    else passes++;
    checks++;
    if (lat !== elat)
      $display("FAIL %s_latency A=%h B=%h got %0d expected %0d", name, a, b, lat, elat);
    else passes++;
    checks++;
    if (da !== 1'b0 || Q !== eq || R !== er)
      $display("FAIL %s_pulse done_next=%b Q=%h R=%h expected done 0 and held Q=%h R=%h", name, da, Q, R, eq, er);
    else passes++;
    checks++;
    if (dz !== edz)
      $display("FAIL %s_divzero got %b expected %b", name, dz, edz);
    else passes++;
  endtask

  task automatic test_directed();
    logic [7:0] ta [9] = '{8'd100, 8'h9C, 8'd100, 8'h80, 8'h80, 8'd7, 8'hF9, 8'd0, 8'h80};
    logic [7:0] tb [9] = '{8'd7,   8'd7,  8'hF9,  8'hFF, 8'd3,  8'd0, 8'd0,  8'd5, 8'd0};
    for (int i = 0; i < 9; i++) check_op("directed", ta[i], tb[i]);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i % 8 == 7) ? 8'h00 : 8'($urandom);
      check_op("random", a, b);
    end
  endtask

  task automatic test_ignore_valid();
    logic [7:0] eq, er;
    logic       edz;
    int         elat, lat, extra;
    model(8'd100, 8'd7, eq, er, edz, elat);
    valid = 1'b1;
    A = 8'd100;
    B = 8'd7;
    @(negedge clk);
    valid = 1'b0;
    lat = 0;
    repeat (2) begin @(negedge clk); lat++; end
    valid = 1'b1;
    A = 8'hCE;
    B = 8'd3;
    repeat (3) begin @(negedge clk); lat++; end
    valid = 1'b0;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    $display("op A=100 B=7 with mid-run valid -> Q=%h R=%h latency=%0d", Q, R, lat);
    checks++;
    if (Q !== eq || R !== er || lat !== elat)
      $display("FAIL ignore_valid got Q=%h R=%h lat=%0d expected Q=%h R=%h lat=%0d", Q, R, lat, eq, er, elat);
    else passes++;
    extra = 0;
    repeat (15) begin @(negedge clk); if (done === 1'b1) extra++; end
    checks++;
    if (extra !== 0)
      $display("FAIL ignore_valid_queued got %0d extra done pulses expected 0", extra);
    else passes++;
  endtask

  task automatic test_reset_midop();
    int pulses;
    valid = 1'b1;
    A = 8'h9C;
    B = 8'd7;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({Q, R, done, dz_now()} !== 18'h0)
      $display("FAIL reset_midop Q=%h R=%h done=%b dz=%b expected all zero", Q, R, done, dz_now());
    else passes++;
    pulses = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) pulses++; end
    rst = 1'b1;
    repeat (14) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++;
    if (pulses !== 0)
      $display("FAIL reset_abandon got %0d done pulses expected 0", pulses);
    else passes++;
    // Request presented on the very first edge after reset release.
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_op("after_reset", 8'h9C, 8'd7);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_valid();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
